seg_dynamic_drv: RTL and testbench
==================================

Name: seg_dynamic_drv

Overview:
- Consumer end of the display data interface: accepts a 20-bit binary value, decimal-point mask, sign flag and enable from the data generator.
- Converts the value to 6 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Applies leading-zero blanking, sign and point placement.
- Time-multiplexes the result onto a 6-digit common-anode display as one-hot digit select plus active-low segment code, which feeds the 74HC595 serializer.

Parameters:
- CNT_MAX, 16'd49_999, digit dwell minus one, in sys_clk cycles (1 ms at 50 MHz).
- NUM_MAX, 20'd999_999, largest displayable value; larger inputs saturate to it.

Ports:
- sys_clk  input  1  system clock; single clock domain.
- sys_rst  input  1  synchronous, active-high reset.
- data  input  20  unsigned binary value to display.
- point  input  6  point[i]=1 lights the DP of digit i; digit 0 is rightmost.
- sign  input  1  1 = show minus sign.
- seg_en  input  1  1 = display on; 0 = blank all digits.
- sel  output  6  one-hot digit select, active-high; sel[i] drives digit i.
- seg  output  8  segment code, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - FSM goes to IDLE; cnt_dwell=0; scan index=0.
  - Display buffer all blank; sel=6'b000000; seg=8'hFF.
- Conversion FSM, IDLE → SHIFT → DONE → IDLE:
  - IDLE (1 cycle): capture data (saturated to NUM_MAX if larger), point and sign; clear the 24-bit BCD accumulator.
  - SHIFT (exactly 20 cycles): each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, taking the binary MSB.
  - DONE (1 cycle): commit the 6 nibbles, captured point and captured sign to the display buffer atomically.
  - Loop period is 22 cycles. A change on data appears in the display buffer at most 43 cycles later. Inputs arriving mid-conversion are ignored until the next IDLE.
- Blanking (display buffer formation):
  - Digit i is "significant" if its nibble ≠0, or point[i]=1, or i=0, or any higher digit is significant.
  - Non-significant digits are blank (8'hFF).
  - If sign=1: the minus (8'hBF) goes in the lowest non-significant digit position above the significant span. If all 6 digits are significant, the sign is dropped.
  - DP: bit7 forced 0 on digit i when point[i]=1; this also applies to blank or minus digits.
- Decode: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Scan:
  - cnt_dwell counts 0..CNT_MAX, then wraps to 0.
  - On wrap, the scan index advances 0→1→…→5→0.
  - sel and seg are registered from the index and buffer: one cycle behind the index, always coherent, never two digits active.
- seg_en=0:
  - sel=0 and seg=8'hFF from the next cycle.
  - Counters and conversion keep running, so the display resumes mid-scan with no glitch when seg_en returns to 1.
- Reset mid-conversion aborts the conversion; the buffer stays blank until the first DONE after release.

Optional Feature:
- Macro SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking and sign placement exactly as above.
- Undefined:
  - All 6 digits always shown, including leading zeros.
  - The sign input is ignored; no minus is ever drawn.
  - Point behaviour is unchanged.
  - Blanking logic is removed from the netlist.

Test Plan:
- CNT_MAX=4, reset held 3 cycles → sel=0, seg=FF throughout. After release, seg_en=1, data=0: first non-blank frame shows digit0=C0, digits 1–5 = FF. sel steps 000001→000010… every 5 cycles.
- data=20'd123456, point=0, sign=0 → over one scan, digits 0..5 = 82, 92, 99, B0, A4, F9. One-hot sel, 5 cycles each.
- data=20'd42, sign=1, point=6'b000010 → digit0=A4, digit1=99 with DP (0x19), digit2=BF, digits 3–5 = FF.
- data=20'd1_048_575 → saturates: all six digits = 90. data=999_999 with sign=1 → all 90, no minus.
- Change data 0→7 in the cycle after IDLE capture → buffer still shows 0 for the 22-cycle conversion; digit0=F8 within 43 cycles. Pulse sys_rst mid-SHIFT → outputs immediately 000000/FF, then recover.
- seg_en toggled 1→0→1 mid-dwell → sel=0/seg=FF the cycle after the drop. On return, scan continues at the same index and count. Repeat the 123456 case with SEG_LZ_BLANK_EN undefined and data=42 → digits 2–5 show C0.

Source files
------------

// File: rtl/seg_dynamic_drv.sv
// rtl/seg_dynamic_drv.sv - 6-digit multiplexed 7-segment driver with double-dabble BCD conversion
// Optional feature macro: SEG_LZ_BLANK_EN (leading-zero blanking and minus-sign placement).
module seg_dynamic_drv #(
  parameter logic [15:0] CNT_MAX = 16'd49_999,
  parameter logic [19:0] NUM_MAX = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load;
  logic        shift_en;
  logic        commit;
  logic [4:0]  cnt_shift;
  logic [19:0] bin_sr;
  logic [23:0] bcd_acc;
  logic [23:0] bcd_adj;
  logic [5:0]  point_cap;
  logic [7:0]  disp_buf [6];
  logic [7:0]  disp_nxt [6];
  logic [15:0] cnt_dwell;
  logic [2:0]  scan_idx;

  // Active-low 7-segment code for one BCD digit, {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  // Conversion state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: one capture cycle, 20 shift cycles, one commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   if (cnt_shift == 5'd19) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE:    load     = 1'b1;
      SHIFT:   shift_en = 1'b1;
      DONE:    commit   = 1'b1;
      default: load     = 1'b0;
    endcase
  end

  // Add 3 to every nibble of 5 or more ahead of the shift
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 6; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // Capture saturated input, then shift the binary MSB into the BCD accumulator
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_shift <= '0;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      point_cap <= '0;
    end else if (load) begin
      cnt_shift <= '0;
      bin_sr    <= (data > NUM_MAX) ? NUM_MAX : data;
      bcd_acc   <= '0;
      point_cap <= point;
    end else if (shift_en) begin
      cnt_shift <= cnt_shift + 5'd1;
      bin_sr    <= {bin_sr[18:0], 1'b0};
      bcd_acc   <= {bcd_adj[22:0], bin_sr[19]};
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic       sign_cap;
  logic [5:0] sig;
  logic [5:0] minus_pos;

  // Sign is sampled together with the value so a frame is always self-consistent
  always_ff @(posedge sys_clk) begin
    if (sys_rst)   sign_cap <= 1'b0;
    else if (load) sign_cap <= sign;
  end

  // Significance spans downward from the highest nonzero or pointed digit; minus sits just above it
  always_comb begin
    sig = '0;
    sig[5] = (bcd_acc[23:20] != 4'd0) | point_cap[5];
    for (int i = 4; i >= 1; i--) begin
      sig[i] = (bcd_acc[4*i +: 4] != 4'd0) | point_cap[i] | sig[i+1];
    end
    sig[0] = 1'b1;
    minus_pos = ~sig & {sig[4:0], 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (sig[i])                         disp_nxt[i] = seg_decode(bcd_acc[4*i +: 4]);
      else if (sign_cap && minus_pos[i])  disp_nxt[i] = 8'hBF;
      else                                disp_nxt[i] = 8'hFF;
      if (point_cap[i]) disp_nxt[i][7] = 1'b0;
    end
  end
`else
  logic sign_unused;
  assign sign_unused = sign;

  // Every digit shown, leading zeros included
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      disp_nxt[i] = seg_decode(bcd_acc[4*i +: 4]);
      if (point_cap[i]) disp_nxt[i][7] = 1'b0;
    end
  end
`endif

  // Display buffer: blank from reset, replaced as a whole on each commit
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 6; i++) disp_buf[i] <= 8'hFF;
    end else if (commit) begin
      for (int i = 0; i < 6; i++) disp_buf[i] <= disp_nxt[i];
    end
  end

  // Dwell counter and scan index keep running regardless of seg_en
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_dwell <= '0;
      scan_idx  <= '0;
    end else if (cnt_dwell == CNT_MAX) begin
      cnt_dwell <= '0;
      scan_idx  <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      cnt_dwell <= cnt_dwell + 16'd1;
    end
  end

  // Registered digit select and segment code, taken from the same index
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'b000001 << scan_idx;
      seg <= disp_buf[scan_idx];
    end else begin
      sel <= '0;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_drv.sv
// tb/tb_seg_dynamic_drv.sv - self-checking bench for seg_dynamic_drv
`timescale 1ns/1ps
module tb_seg_dynamic_drv;

  localparam logic [15:0] CNT_MAX = 16'd4;
  localparam int DWELL = 5;
  localparam int LOOP  = 22;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [19:0] data    = '0;
  logic [5:0]  point   = '0;
  logic        sign    = 1'b0;
  logic        seg_en  = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  seg_dynamic_drv #(.CNT_MAX(CNT_MAX), .NUM_MAX(20'd999_999)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] code_of(input int d);
    case (d)
      0: code_of = 8'hC0; 1: code_of = 8'hF9; 2: code_of = 8'hA4; 3: code_of = 8'hB0;
      4: code_of = 8'h99; 5: code_of = 8'h92; 6: code_of = 8'h82; 7: code_of = 8'hF8;
      8: code_of = 8'h80; default: code_of = 8'h90;
    endcase
  endfunction

  // Expected six-digit frame, digit i at bits [8i+7:8i]
  function automatic logic [47:0] frame_of(input logic [19:0] v_in, input logic [5:0] p, input logic s);
    int v, n;
    int dig[6];
    logic [7:0]  c;
    logic [47:0] f;
    v = (v_in > 20'd999_999) ? 999_999 : int'(v_in);
    for (int i = 0; i < 6; i++) begin
      dig[i] = v % 10;
      v = v / 10;
    end
    n = 1;
    for (int i = 0; i < 6; i++) if (dig[i] != 0 || p[i]) n = i + 1;
    f = '0;
    for (int i = 0; i < 6; i++) begin
      if (!LZ || i < n)  c = code_of(dig[i]);
      else if (s && i == n) c = 8'hBF;
      else               c = 8'hFF;
      if (p[i]) c[7] = 1'b0;
      f[8*i +: 8] = c;
    end
    return f;
  endfunction

  // Timeline model: k counts clock edges since reset; conversion phase and scan slot follow from k
  bit          model_ok = 1'b0;
  bit          live_chk = 1'b0;
  int          k = 0;
  logic [47:0] mframe = '1;
  logic [19:0] cdata  = '0;
  logic [5:0]  cpoint = '0;
  logic        csign  = 1'b0;
  logic [5:0]  exp_sel = '0;
  logic [7:0]  exp_seg = 8'hFF;

  always @(posedge sys_clk) begin : model
    int idx;
    if (sys_rst) begin
      model_ok = 1'b1;
      k        = 0;
      mframe   = '1;
      exp_sel  = '0;
      exp_seg  = 8'hFF;
    end else if (model_ok) begin
      k++;
      idx     = ((k - 1) / DWELL) % 6;
      exp_sel = seg_en ? 6'(1 << idx) : 6'd0;
      exp_seg = seg_en ? mframe[8*idx +: 8] : 8'hFF;
      if (k % LOOP == 1) begin
        cdata  = data;
        cpoint = point;
        csign  = sign;
      end
      if (k % LOOP == 0) mframe = frame_of(cdata, cpoint, csign);
    end
  end

  always @(negedge sys_clk) begin
    if (model_ok && live_chk) begin
      check("live_sel", sel, exp_sel);
      check("live_seg", seg, exp_seg);
      check("live_onehot", ($countones(sel) <= 1), 1'b1);
    end
  end

  typedef struct {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic [47:0] exp_lz;
    logic [47:0] exp_full;
  } vec_t;

  vec_t vecs[10];

  task automatic grab_frame(output logic [47:0] f, output logic [5:0] seen);
    f    = '1;
    seen = '0;
    for (int c = 0; c < 6 * DWELL + 2; c++) begin
      @(negedge sys_clk);
      for (int i = 0; i < 6; i++) begin
        if (sel == 6'(1 << i)) begin
          f[8*i +: 8] = seg;
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [47:0] f, want;
    logic [5:0]  seen, prev;
    int          n;

    vecs[0] = '{20'd0,         6'b000000, 1'b0, 48'hFFFF_FFFF_FFC0, 48'hC0C0_C0C0_C0C0};
    vecs[1] = '{20'd123456,    6'b000000, 1'b0, 48'hF9A4_B099_9282, 48'hF9A4_B099_9282};
    vecs[2] = '{20'd42,        6'b000010, 1'b1, 48'hFFFF_FFBF_19A4, 48'hC0C0_C0C0_19A4};
    vecs[3] = '{20'd1_048_575, 6'b000000, 1'b0, 48'h9090_9090_9090, 48'h9090_9090_9090};
    vecs[4] = '{20'd999_999,   6'b000000, 1'b1, 48'h9090_9090_9090, 48'h9090_9090_9090};
    vecs[5] = '{20'd7,         6'b000000, 1'b0, 48'hFFFF_FFFF_FFF8, 48'hC0C0_C0C0_C0F8};
    vecs[6] = '{20'd5,         6'b100000, 1'b1, 48'h40C0_C0C0_C092, 48'h40C0_C0C0_C092};
    vecs[7] = '{20'd0,         6'b000100, 1'b1, 48'hFFFF_BF40_C0C0, 48'hC0C0_C040_C0C0};
    vecs[8] = '{20'd0,         6'b000000, 1'b1, 48'hFFFF_FFFF_BFC0, 48'hC0C0_C0C0_C0C0};
    vecs[9] = '{20'd99_999,    6'b000000, 1'b1, 48'hBF90_9090_9090, 48'hC090_9090_9090};

    // Reset held three cycles: outputs dark
    repeat (3) begin
      @(negedge sys_clk);
      check("reset_sel", sel, 6'd0);
      check("reset_seg", seg, 8'hFF);
    end
    seg_en  = 1'b1;
    data    = 20'd0;
    sys_rst = 1'b0;
    live_chk = 1'b1;

    // Buffer blank until the first commit
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      check("blank_before_commit", seg, 8'hFF);
    end

    // Dwell of CNT_MAX+1 cycles per digit
    for (int r = 0; r < 2; r++) begin
      prev = sel;
      n = 0;
      while (sel == prev && n < 40) begin @(negedge sys_clk); n++; end
      prev = sel;
      n = 0;
      while (sel == prev && n < 40) begin @(negedge sys_clk); n++; end
      check("dwell_cycles", n, DWELL);
    end

    // Table of display cases
    for (int v = 0; v < 10; v++) begin
      data  = vecs[v].data;
      point = vecs[v].point;
      sign  = vecs[v].sign;
      repeat (50) @(negedge sys_clk);
      grab_frame(f, seen);
      want = LZ ? vecs[v].exp_lz : vecs[v].exp_full;
      check($sformatf("frame_seen_%0d", v), seen, 6'h3F);
      for (int i = 0; i < 6; i++)
        check($sformatf("vec%0d_digit%0d", v, i), f[8*i +: 8], want[8*i +: 8]);
    end

    // Data changes the cycle after capture: old value kept through the conversion
    data = 20'd0; point = '0; sign = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    data = 20'd7;
    repeat (32) @(negedge sys_clk);
    check("latency_old_sel", sel, 6'b000001);
    check("latency_old_seg", seg, 8'hC0);
    repeat (30) @(negedge sys_clk);
    check("latency_new_sel", sel, 6'b000001);
    check("latency_new_seg", seg, 8'hF8);

    // Reset pulse in the middle of a conversion
    data = 20'd123456;
    repeat (60) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (10) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midshift_rst_sel", sel, 6'd0);
    check("midshift_rst_seg", seg, 8'hFF);
    sys_rst = 1'b0;
    repeat (50) @(negedge sys_clk);
    grab_frame(f, seen);
    want = frame_of(20'd123456, 6'd0, 1'b0);
    check("recover_frame", f, want);

    // seg_en drop mid-dwell, then resume
    repeat (2) @(negedge sys_clk);
    seg_en = 1'b0;
    @(negedge sys_clk);
    check("seg_en_off_sel", sel, 6'd0);
    check("seg_en_off_seg", seg, 8'hFF);
    repeat (6) @(negedge sys_clk);
    seg_en = 1'b1;
    repeat (40) @(negedge sys_clk);

    // Randomized inputs against the timeline model
    for (int r = 0; r < 25; r++) begin
      case ($urandom % 4)
        0:       data = 20'($urandom_range(1_048_575, 999_990));
        1:       data = 20'($urandom_range(999, 0));
        default: data = 20'($urandom_range(999_999, 0));
      endcase
      point  = ($urandom % 3 == 0) ? 6'($urandom) : 6'd0;
      sign   = 1'($urandom);
      seg_en = ($urandom % 5 != 0);
      repeat ($urandom_range(80, 10)) @(negedge sys_clk);
    end

    live_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
